imm_encoder: RTL
================

# imm_encoder

- Converts a numeric value plus an instruction template into encoded RV32I instruction words. It is the inverse of the immediate-extension decoder: it scatters a value into the I/S/B/U/J immediate fields.
- Also expands the `li rd, value` pseudo-instruction into LUI/ADDI sequences.
- Feeds the debug program buffer and the trap-stub generator through a valid/ready stream, one registered word at a time.

## Interface
Parameters:
- none; field layouts and op codes come from `defines.v`

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  3  `EXT_I`/`EXT_S`/`EXT_B`/`EXT_U`/`EXT_J`, or `EXT_LI`
- in_tmpl  in  32  template word; its immediate bits are ignored and overwritten. For `EXT_LI`, only [11:7] (rd) is used.
- in_val  in  32  value to encode
- out_valid  out  1  out_inst valid
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- out_err  out  1  value not representable in the selected format
- out_last  out  1  final word of the current request

## Operation
- FSM states: IDLE, SINGLE, LI_HI, LI_LO.
  - IDLE → SINGLE: on accept with a non-LI op.
  - IDLE → LI_HI: on accept with `EXT_LI`, when the two-word form applies.
  - IDLE → SINGLE: on accept with `EXT_LI`, when the one-word form applies.
  - LI_HI → LI_LO: on out_ready.
  - SINGLE/LI_LO → IDLE: on out_ready, unless a new request is accepted in the same cycle.
- in_ready = (state==IDLE) || (out_ready && state∈{SINGLE, LI_LO}). Back-to-back requests give one word per cycle.
- Field placement. Template immediate bits are cleared, then:
  - I: [31:20]=val[11:0]
  - S: [31:25]=val[11:5], [11:7]=val[4:0]
  - B: [31]=val[12], [7]=val[11], [30:25]=val[10:5], [11:8]=val[4:1]
  - U: [31:12]=val[31:12]
  - J: [31]=val[20], [19:12]=val[19:12], [20]=val[11], [30:21]=val[10:1]
- Range rules (out_err=1 on violation; the truncated word is still emitted):
  - I/S: val is the sign-extension of val[11:0]
  - B: val is the sign-extension of val[12:0], and val[0]==0
  - J: val is the sign-extension of val[20:0], and val[0]==0
  - U: val[11:0]==0
  - Undefined op: emits the template unchanged with err=1.
- Round-trip property: whenever out_err=0, the immediate decoder applied to (op, out_inst) returns in_val.
- LI expansion:
  - hi = (in_val + 32'h800)[31:12], modulo 2^32 (carry out dropped); lo = in_val[11:0].
  - hi≠0, lo≠0: LUI rd,hi (opcode `OPC_LUI`), then ADDI rd,rd,lo (`OPC_OP_IMM`, funct3 000).
  - hi==0: single word ADDI rd,x0,lo.
  - lo==0, hi≠0: single word LUI rd,hi.
  - out_last=1 only on the final word. LI never raises out_err.
- rd=x0 with LI is encoded as given; no special case.

## Timing
- Reset values: state IDLE, out_valid=0, out_inst=0, out_err=0, out_last=0. in_ready=1 one cycle after reset deassertion is not required; it is high as soon as rst_n is high.
- Latency: the word is registered; out_valid rises the cycle after acceptance.
- While out_valid && !out_ready: out_inst, out_err and out_last hold stable, and in_ready=0.
- The second LI word appears the cycle after the first word is accepted.
- Reset asserted mid-operation, including between the LI words: the pending word is discarded and the block returns to IDLE.

## Configuration
- `IMM_ENCODER_RANGE_CHECK_EN`
  - Defined: range rules are evaluated and drive out_err.
  - Undefined: the check logic is removed and out_err is tied 0. Field placement is unchanged.

## Structure
- `defines.v` holds:
  - existing `EXT_I..EXT_J` codes
  - new `EXT_LI` (3'b110)
  - `OPC_LUI` (7'b0110111), `OPC_OP_IMM` (7'b0010011)
  - immediate field masks per format
- Sub-module `imm_pack`: combinational (op, tmpl, val) → (inst, err). It is instantiated once and is reused for both LI words.

## Test plan
- I-format:
  - op=`EXT_I`, tmpl=0x00000293, val=0xFFFFFFFF → 0xFFF00293, err=0, last=1
  - same tmpl, val=0x00000800 → err=1
- B-format: op=`EXT_B`, tmpl=0x00000063, val=0xFFFFFFFE → 0xFE000FE3, err=0. Repeat with val=0x00001001 → err=1.
- LI two-word: tmpl rd=1, val=0x12345FFF → 0x123460B7 (last=0), then 0xFFF08093 (last=1).
- LI one-word wrap: val=0xFFFFF800 → single 0x80000093, last=1.
- Backpressure: hold out_ready=0 for 3 cycles mid-LI → word stable, in_ready=0; the second word appears the cycle after release.
- Reset: assert rst_n=0 between LUI and ADDI → out_valid=0, no ADDI emitted, in_ready=1 after release.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared op codes, opcodes, immediate field masks and FSM state type for imm_encoder.
package imm_encoder_pkg;

    localparam logic [2:0] EXT_I  = 3'b000;
    localparam logic [2:0] EXT_S  = 3'b001;
    localparam logic [2:0] EXT_B  = 3'b010;
    localparam logic [2:0] EXT_U  = 3'b011;
    localparam logic [2:0] EXT_J  = 3'b100;
    localparam logic [2:0] EXT_LI = 3'b110;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Bits owned by the immediate in each format; everything else comes from the template.
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_LI_HI  = 2'd2,
        ST_LI_LO  = 2'd3
    } state_t;

    // Upper LUI immediate for li: rounds so that adding the sign-extended low 12 bits restores val.
    function automatic logic [19:0] li_hi(input logic [31:0] val);
        logic [31:0] sum;
        sum = val + 32'h0000_0800;
        return sum[31:12];
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational scatter of a value into the immediate fields of a template word.
// Range checking is present only when IMM_ENCODER_RANGE_CHECK_EN is defined.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] tmpl,
    input  logic [31:0] val,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = tmpl;
        case (op)
            EXT_I: inst = (tmpl & ~MASK_I) | {val[11:0], 20'b0};
            EXT_S: inst = (tmpl & ~MASK_S) | {val[11:5], 13'b0, val[4:0], 7'b0};
            EXT_B: inst = (tmpl & ~MASK_B) | {val[12], val[10:5], 13'b0, val[4:1], val[11], 7'b0};
            EXT_U: inst = (tmpl & ~MASK_U) | {val[31:12], 12'b0};
            EXT_J: inst = (tmpl & ~MASK_J) | {val[20], val[10:1], val[11], val[19:12], 12'b0};
            default: inst = tmpl;
        endcase
    end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    // A value fits when all bits above the field's sign bit replicate it.
    always_comb begin
        err = 1'b0;
        case (op)
            EXT_I, EXT_S: err = (val[31:11] != {21{val[11]}});
            EXT_B:        err = (val[31:12] != {20{val[12]}}) || val[0];
            EXT_U:        err = (val[11:0] != 12'b0);
            EXT_J:        err = (val[31:20] != {12{val[20]}}) || val[0];
            default:      err = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: registered valid/ready stream of encoded RV32I words, including li expansion.
// Optional range checking is enabled by defining IMM_ENCODER_RANGE_CHECK_EN.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_tmpl,
    input  logic [31:0] in_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last,
    output state_t      dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and a presented word (or request) holds stable until transferred.

    state_t      state_q, state_d;
    logic [4:0]  rd_q;
    logic [11:0] lo_q;

    logic [19:0] req_hi;
    logic [11:0] req_lo;
    logic        req_li, req_two;
    logic        accept, load_lo;

    logic [2:0]  pk_op;
    logic [31:0] pk_tmpl, pk_val, pk_inst;
    logic        pk_err;

    assign req_hi  = li_hi(in_val);
    assign req_lo  = in_val[11:0];
    assign req_li  = (in_op == EXT_LI);
    assign req_two = req_li && (req_hi != 20'b0) && (req_lo != 12'b0);

    assign in_ready  = (state_q == ST_IDLE) ||
                       (out_ready && ((state_q == ST_SINGLE) || (state_q == ST_LI_LO)));
    assign accept    = in_valid && in_ready;
    assign load_lo   = (state_q == ST_LI_HI) && out_ready;
    assign out_valid = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    // The single packer serves the incoming request and, from LI_HI, the saved ADDI half.
    always_comb begin
        pk_op   = in_op;
        pk_tmpl = in_tmpl;
        pk_val  = in_val;
        if (state_q == ST_LI_HI) begin
            pk_op   = EXT_I;
            pk_tmpl = {12'b0, rd_q, 3'b000, rd_q, OPC_OP_IMM};
            pk_val  = {{20{lo_q[11]}}, lo_q};
        end else if (req_li) begin
            if (req_hi == 20'b0) begin
                pk_op   = EXT_I;
                pk_tmpl = {12'b0, 5'b0, 3'b000, in_tmpl[11:7], OPC_OP_IMM};
                pk_val  = {{20{req_lo[11]}}, req_lo};
            end else begin
                pk_op   = EXT_U;
                pk_tmpl = {20'b0, in_tmpl[11:7], OPC_LUI};
                pk_val  = {req_hi, 12'b0};
            end
        end
    end

    imm_pack u_pack (
        .op   (pk_op),
        .tmpl (pk_tmpl),
        .val  (pk_val),
        .inst (pk_inst),
        .err  (pk_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = req_two ? ST_LI_HI : ST_SINGLE;
            ST_LI_HI: if (out_ready) state_d = ST_LI_LO;
            default:  if (out_ready) state_d = accept ? (req_two ? ST_LI_HI : ST_SINGLE) : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            out_inst <= 32'b0;
            out_err  <= 1'b0;
            out_last <= 1'b0;
            rd_q     <= 5'b0;
            lo_q     <= 12'b0;
        end else begin
            state_q <= state_d;
            if (accept || load_lo) begin
                out_inst <= pk_inst;
                out_err  <= pk_err;
                out_last <= !(accept && req_two);
            end
            if (accept) begin
                rd_q <= in_tmpl[11:7];
                lo_q <= req_lo;
            end
        end
    end

endmodule
